// File: rtl/snake_apple_module.sv
// Apple side of the snake game: eat detection, grow pulse, pseudo-random relocation,
// score keeping and scan-cell classification for the colour mux.
module snake_apple_module #(
    parameter int unsigned X_MIN     = 1,
    parameter int unsigned X_MAX     = 38,
    parameter int unsigned Y_MIN     = 1,
    parameter int unsigned Y_MAX     = 28,
    parameter int unsigned INIT_X    = 24,
    parameter int unsigned INIT_Y    = 10,
    parameter int unsigned ADD_HOLD  = 8,
    parameter int unsigned MAX_TRIES = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       Clk_50mhz,
    input  logic       Rst,
    input  logic [2:0] Game_status,
    input  logic [5:0] Head_x,
    input  logic [5:0] Head_y,
    input  logic [9:0] Pixel_x,
    input  logic [9:0] Pixel_y,
    output logic [5:0] Apple_x,
    output logic [5:0] Apple_y,
    output logic       Body_add_sig,
    output logic [7:0] Score,
    output logic       Apple_obj
);

    localparam int unsigned HOLD_W = (ADD_HOLD > 1) ? $clog2(ADD_HOLD) : 1;
    localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ADD_HOLD - 1);
    localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);
    localparam logic [5:0]        X_LO      = 6'(X_MIN);
    localparam logic [5:0]        X_HI      = 6'(X_MAX);
    localparam logic [5:0]        Y_LO      = 6'(Y_MIN);
    localparam logic [5:0]        Y_HI      = 6'(Y_MAX);
    localparam logic [5:0]        INIT_XC   = 6'(INIT_X);
    localparam logic [5:0]        INIT_YC   = 6'(INIT_Y);
    localparam logic [15:0]       SEED_C    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [2:0]        GS_PLAY   = 3'b010;
    localparam logic [2:0]        GS_END    = 3'b100;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_EAT    = 2'd1,
        S_SEARCH = 2'd2
    } state_t;

    state_t            state;
    logic [15:0]       lfsr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TRY_W-1:0]  try_cnt;

    logic       lfsr_fb;
    logic [5:0] cand_x;
    logic [5:0] cand_y;
    logic       cand_ok;
    logic       head_hit;
    logic       init_on_head;

    // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign cand_x  = lfsr[5:0];
    assign cand_y  = lfsr[11:6];

    assign cand_ok = (cand_x >= X_LO) && (cand_x <= X_HI) &&
                     (cand_y >= Y_LO) && (cand_y <= Y_HI) &&
                     !((cand_x == Head_x) && (cand_y == Head_y));

    assign head_hit     = (Head_x == Apple_x) && (Head_y == Apple_y);
    assign init_on_head = (Head_x == INIT_XC) && (Head_y == INIT_YC);

    // Apple is hidden while it is being relocated
    assign Apple_obj = (Pixel_x < 10'd640) && (Pixel_y < 10'd480) &&
                       (Pixel_x[9:4] == Apple_x) && (Pixel_y[9:4] == Apple_y) &&
                       (state != S_SEARCH);

    always_ff @(posedge Clk_50mhz) begin
        if (Rst) begin
            state        <= S_WAIT;
            lfsr         <= SEED_C;
            hold_cnt     <= '0;
            try_cnt      <= '0;
            Apple_x      <= INIT_XC;
            Apple_y      <= INIT_YC;
            Body_add_sig <= 1'b0;
            Score        <= 8'd0;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
            if (Game_status == GS_PLAY) begin
                case (state)
                    S_WAIT: begin
                        if (head_hit) begin
                            state        <= S_EAT;
                            Body_add_sig <= 1'b1;
                            hold_cnt     <= HOLD_LOAD;
                            if (Score != 8'hFF) begin
                                Score <= Score + 8'd1;
                            end
                        end
                    end
                    S_EAT: begin
                        if (hold_cnt == '0) begin
                            Body_add_sig <= 1'b0;
                            state        <= S_SEARCH;
                            try_cnt      <= '0;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                    S_SEARCH: begin
                        if (cand_ok) begin
                            Apple_x <= cand_x;
                            Apple_y <= cand_y;
                            state   <= S_WAIT;
                        end else if (try_cnt == TRY_LAST) begin
                            // out of draws: fixed cell, nudged off the head if needed
                            Apple_x <= init_on_head ? X_LO : INIT_XC;
                            Apple_y <= init_on_head ? Y_LO : INIT_YC;
                            state   <= S_WAIT;
                        end else begin
                            try_cnt <= try_cnt + TRY_W'(1);
                        end
                    end
                    default: begin
                        state <= S_WAIT;
                    end
                endcase
            end else begin
                // END keeps the score for the end screen; START and illegal codes clear it
                state        <= S_WAIT;
                hold_cnt     <= '0;
                try_cnt      <= '0;
                Apple_x      <= INIT_XC;
                Apple_y      <= INIT_YC;
                Body_add_sig <= 1'b0;
                if (Game_status != GS_END) begin
                    Score <= 8'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_apple_module.sv
// Randomised self-checking bench for snake_apple_module against a cycle-level reference model.
module tb_snake_apple_module;

    localparam int PLAY = 2;
    localparam int ENDG = 4;

    logic       clk;
    logic       Rst;
    logic [2:0] gs;
    logic [5:0] hx, hy;
    logic [9:0] px, py;
    logic [5:0] ax, ay;
    logic       body;
    logic [7:0] score;
    logic       obj;

    logic [2:0] g2;
    logic [5:0] h2x, h2y;
    logic [9:0] p2x, p2y;
    logic [5:0] a2x, a2y;
    logic       b2;
    logic [7:0] s2;
    logic       o2;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    int m_lfsr, m_ax, m_ay, m_score, m_pulse, m_tries;
    bit m_search;

    snake_apple_module dut (
        .Clk_50mhz(clk), .Rst(Rst), .Game_status(gs), .Head_x(hx), .Head_y(hy),
        .Pixel_x(px), .Pixel_y(py), .Apple_x(ax), .Apple_y(ay),
        .Body_add_sig(body), .Score(score), .Apple_obj(obj)
    );

    // Empty column range: every draw is rejected, so only the fallback path is reachable
    snake_apple_module #(.X_MIN(1), .X_MAX(0)) dut2 (
        .Clk_50mhz(clk), .Rst(Rst), .Game_status(g2), .Head_x(h2x), .Head_y(h2y),
        .Pixel_x(p2x), .Pixel_y(p2y), .Apple_x(a2x), .Apple_y(a2y),
        .Body_add_sig(b2), .Score(s2), .Apple_obj(o2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lfsr_next(input int l);
        int b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    // Reference model: pulse counts remaining high cycles, search counts draws made
    always @(posedge clk) begin
        int cx, cy;
        if (Rst) begin
            m_lfsr = 16'hACE1; m_ax = 24; m_ay = 10; m_score = 0;
            m_pulse = 0; m_search = 0; m_tries = 0;
        end else begin
            cx = m_lfsr % 64;
            cy = (m_lfsr / 64) % 64;
            m_lfsr = lfsr_next(m_lfsr);
            if (int'(gs) == PLAY) begin
                if (m_pulse > 0) begin
                    m_pulse--;
                    if (m_pulse == 0) begin m_search = 1; m_tries = 0; end
                end else if (m_search) begin
                    m_tries++;
                    if (cx >= 1 && cx <= 38 && cy >= 1 && cy <= 28 &&
                        !(cx == int'(hx) && cy == int'(hy))) begin
                        m_ax = cx; m_ay = cy; m_search = 0;
                    end else if (m_tries == 64) begin
                        if (int'(hx) == 24 && int'(hy) == 10) begin m_ax = 1; m_ay = 1; end
                        else begin m_ax = 24; m_ay = 10; end
                        m_search = 0;
                    end
                end else if (int'(hx) == m_ax && int'(hy) == m_ay) begin
                    m_pulse = 8;
                    if (m_score < 255) m_score++;
                end
            end else begin
                m_ax = 24; m_ay = 10; m_pulse = 0; m_search = 0;
                if (int'(gs) != ENDG) m_score = 0;
            end
        end
    end

    always @(negedge clk) begin
        int e_obj;
        if (chk_en) begin
            e_obj = (px < 640 && py < 480 && int'(px) / 16 == m_ax &&
                     int'(py) / 16 == m_ay && !m_search) ? 1 : 0;
            check_eq("apple_x", int'(ax), m_ax);
            check_eq("apple_y", int'(ay), m_ay);
            check_eq("body_add", int'(body), (m_pulse > 0) ? 1 : 0);
            check_eq("score", int'(score), m_score);
            check_eq("apple_obj", int'(obj), e_obj);
        end
    end

    task automatic tick();
        int v;
        if ($urandom_range(0, 1) == 1) begin
            v = m_ax * 16 + int'($urandom_range(0, 31)) - 8;
            if (v < 0) v = 0;
            px = 10'(v);
            v = m_ay * 16 + int'($urandom_range(0, 31)) - 8;
            if (v < 0) v = 0;
            py = 10'(v);
        end else begin
            px = 10'($urandom_range(0, 1023));
            py = 10'($urandom_range(0, 1023));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pix_check(input string tag, input int x, input int y, input int exp);
        px = 10'(x);
        py = 10'(y);
        #1;
        check_eq(tag, int'(obj), exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises, highs, n, r;
        bit prev;

        Rst = 1'b1; gs = 3'b001; hx = 6'd0; hy = 6'd0; px = '0; py = '0;
        g2 = 3'b001; h2x = 6'd0; h2y = 6'd0; p2x = '0; p2y = '0;
        repeat (3) @(posedge clk);
        #1;
        Rst = 1'b0;
        tick();

        // Reset / START state and scan-cell boundaries
        check_eq("rst_apple_x", int'(ax), 24);
        check_eq("rst_apple_y", int'(ay), 10);
        check_eq("rst_body", int'(body), 0);
        check_eq("rst_score", int'(score), 0);
        pix_check("obj_left_out", 383, 165, 0);
        pix_check("obj_left_in", 384, 160, 1);
        pix_check("obj_right_in", 399, 175, 1);
        pix_check("obj_right_out", 400, 170, 0);
        pix_check("obj_top_out", 390, 159, 0);
        pix_check("obj_bot_out", 390, 176, 0);
        chk_en = 1;

        // First eat: 8-cycle pulse, then relocation
        gs = 3'(PLAY); hx = 6'd24; hy = 6'd10;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_eq($sformatf("pulse_edge%0d", k), int'(body), (k <= 8) ? 1 : 0);
            if (k == 1) check_eq("score_first", int'(score), 1);
        end
        n = 0;
        while (m_search && n < 70) begin tick(); n++; end
        check_eq("new_apple_range", (ax >= 1 && ax <= 38 && ay >= 1 && ay <= 28) ? 1 : 0, 1);
        check_eq("new_apple_moved", (ax != 6'd24 || ay != 6'd10) ? 1 : 0, 1);

        // Head parked on the apple: exactly one pulse
        hx = 6'(m_ax); hy = 6'(m_ay);
        rises = 0; highs = 0; prev = body;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (body && !prev) rises++;
            if (body) highs++;
            prev = body;
        end
        check_eq("single_pulse_rises", rises, 1);
        check_eq("single_pulse_len", highs, 8);

        // END in the middle of a pulse
        hx = 6'(m_ax); hy = 6'(m_ay);
        tick(); tick(); tick();
        gs = 3'(ENDG);
        tick();
        check_eq("end_body_drop", int'(body), 0);
        check_eq("end_apple_x", int'(ax), 24);
        check_eq("end_apple_y", int'(ay), 10);
        check_eq("end_score_kept", int'(score), 3);
        gs = 3'b001;
        tick();
        check_eq("start_score_clr", int'(score), 0);

        // END arriving on the same edge as a head hit
        gs = 3'(PLAY); hx = 6'd0; hy = 6'd0;
        tick();
        gs = 3'(ENDG); hx = 6'd24; hy = 6'd10;
        tick();
        check_eq("end_vs_eat_body", int'(body), 0);
        tick();
        check_eq("end_vs_eat_body2", int'(body), 0);

        // Random status and head traffic
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) gs = 3'(ENDG);
            else if (r < 3) gs = 3'b001;
            else if (r < 4) gs = 3'($urandom_range(0, 7));
            else gs = 3'(PLAY);
            if ($urandom_range(0, 9) < 4) begin hx = 6'(m_ax); hy = 6'(m_ay); end
            else begin hx = 6'($urandom_range(0, 63)); hy = 6'($urandom_range(0, 63)); end
            tick();
        end

        // Score saturation
        gs = 3'b001;
        tick();
        gs = 3'(PLAY);
        for (int e = 0; e < 260; e++) begin
            hx = 6'(m_ax); hy = 6'(m_ay);
            tick();
            if (e == 0) check_eq("sat_first", int'(score), 1);
            if (e == 254) check_eq("sat_reach", int'(score), 255);
            n = 0;
            while ((m_pulse > 0 || m_search) && n < 100) begin tick(); n++; end
        end
        check_eq("sat_final", int'(score), 255);

        // Fallback placement with head on the initial cell
        g2 = 3'(PLAY); h2x = 6'd24; h2y = 6'd10;
        p2x = 10'(24 * 16 + 3); p2y = 10'(10 * 16 + 3);
        tick();
        repeat (8) tick();
        check_eq("fb_body_low", int'(b2), 0);
        check_eq("fb_hidden", int'(o2), 0);
        repeat (63) tick();
        check_eq("fb1_still_x", int'(a2x), 24);
        check_eq("fb1_still_hidden", int'(o2), 0);
        tick();
        check_eq("fb1_x", int'(a2x), 1);
        check_eq("fb1_y", int'(a2y), 1);
        p2x = 10'(16 + 5); p2y = 10'(16 + 5);
        #1;
        check_eq("fb1_visible", int'(o2), 1);

        // Fallback placement with head elsewhere
        h2x = 6'd1; h2y = 6'd1;
        tick();
        h2x = 6'd5; h2y = 6'd5;
        repeat (8) tick();
        repeat (63) tick();
        check_eq("fb2_still_x", int'(a2x), 1);
        tick();
        check_eq("fb2_x", int'(a2x), 24);
        check_eq("fb2_y", int'(a2y), 10);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
